// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over req/ack,
// and presents it as IR. Optional misaligned-PC trap is enabled by `IFU_ALIGN_CHK_EN.
module instr_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] k,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_HOLD  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_PLUS4 = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_IN    = 2'b11;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [31:0] r_ir, w_ir_nxt;
  logic        r_ir_valid, w_ir_valid_nxt;
  logic        r_fault, w_fault_nxt;

  logic [63:0] w_pc_plus4;
  logic [63:0] w_pc_jump;
  logic [63:0] w_pc_target;
  logic [63:0] w_pc_load_val;
  logic        w_misaligned;

  assign w_pc_plus4 = r_pc + 64'd4;
  // Shift in 64-bit context drops k[63:62] and wraps modulo 2^64.
  assign w_pc_jump  = r_pc + (k << 2);

  always_comb begin
    w_pc_target = r_pc;
    unique case (pc_sel)
      PC_HOLD:  w_pc_target = r_pc;
      PC_PLUS4: w_pc_target = w_pc_plus4;
      PC_JUMP:  w_pc_target = w_pc_jump;
      PC_IN:    w_pc_target = pc_in;
      default:  w_pc_target = r_pc;
    endcase
  end

`ifdef IFU_ALIGN_CHK_EN
  assign w_pc_load_val = w_pc_target;
  assign w_misaligned  = |w_pc_target[1:0];
`else
  assign w_pc_load_val = w_pc_target & ~64'h3;
  assign w_misaligned  = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_valid_nxt = r_ir_valid;
    w_fault_nxt    = r_fault;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          w_ir_nxt       = imem_rdata;
          w_ir_valid_nxt = 1'b1;
          w_state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_load) begin
          w_pc_nxt       = w_pc_load_val;
          w_ir_valid_nxt = 1'b0;
          if (w_misaligned) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_FAULT: w_ir_valid_nxt = 1'b0;  // parked until reset
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET;
      r_ir       <= 32'h0;
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign IR        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign fault     = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; honours `IFU_ALIGN_CHK_EN when defined.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_load = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [63:0] k = 64'h0;
  logic [63:0] pc_in = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IR;
  logic        ir_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fault;

  int n_checks = 0;
  int n_pass = 0;

  instr_fetch_unit #(.PC_RESET(64'h0)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .k          (k),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Completes a fetch; caller guarantees the DUT is in its request state.
  task automatic fetch(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [63:0] kv, input logic [63:0] pv);
    pc_load = 1'b1;
    pc_sel  = sel;
    k       = kv;
    pc_in   = pv;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (pc !== 64'h0) $display("FAIL rst_pc: got %h want %h", pc, 64'h0);
    else n_pass++;
    n_checks++; if (IR !== 32'h0) $display("FAIL rst_ir: got %h want %h", IR, 32'h0);
    else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL rst_ir_valid: got %b want 0", ir_valid);
    else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault);
    else n_pass++;
    n_checks++; if (imem_addr !== 64'h0) $display("FAIL rst_addr: got %h want 0", imem_addr);
    else n_pass++;
    n_checks++; if (pc_plus4 !== 64'h4) $display("FAIL rst_plus4: got %h want 4", pc_plus4);
    else n_pass++;
  endtask

  task automatic test_first_fetch();
    reset = 1'b1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req);
    else n_pass++;
    tick();
    n_checks++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req);
    else n_pass++;
    n_checks++; if (imem_addr !== 64'h0) $display("FAIL first_addr: got %h want 0", imem_addr);
    else n_pass++;
    fetch(32'hAA0003E3);
    n_checks++; if (IR !== 32'hAA0003E3) $display("FAIL first_ir: got %h want aa0003e3", IR);
    else n_pass++;
    n_checks++; if (ir_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", ir_valid);
    else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL hold_req: got %b want 0", imem_req);
    else n_pass++;
  endtask

  task automatic test_plus4();
    load(2'b01, 64'h0, 64'h0);
    n_checks++; if (pc !== 64'h4) $display("FAIL plus4_pc: got %h want 4", pc);
    else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL plus4_valid: got %b want 0", ir_valid);
    else n_pass++;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL plus4_req: got %b want 1", imem_req);
    else n_pass++;
    n_checks++; if (imem_addr !== 64'h4) $display("FAIL plus4_addr: got %h want 4", imem_addr);
    else n_pass++;
    fetch(32'h8B010000);
    n_checks++; if (IR !== 32'h8B010000) $display("FAIL plus4_ir: got %h want 8b010000", IR);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    load(2'b01, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8 || IR !== 32'h8B010000 || ir_valid !== 1'b0)
        $display("FAIL wait_%0d: req=%b addr=%h ir=%h v=%b want 1 8 8b010000 0",
                 i, imem_req, imem_addr, IR, ir_valid);
      else n_pass++;
    end
    fetch(32'h11112222);
    n_checks++; if (IR !== 32'h11112222) $display("FAIL wait_ir: got %h want 11112222", IR);
    else n_pass++;
    n_checks++; if (ir_valid !== 1'b1) $display("FAIL wait_valid: got %b want 1", ir_valid);
    else n_pass++;
  endtask

  task automatic test_jump();
    load(2'b11, 64'h0, 64'h100);
    fetch(32'h0);
    load(2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    n_checks++; if (pc !== 64'hF8) $display("FAIL jump_pc: got %h want f8", pc);
    else n_pass++;
    n_checks++; if (imem_addr !== 64'hF8) $display("FAIL jump_addr: got %h want f8", imem_addr);
    else n_pass++;
    fetch(32'h33334444);
  endtask

  task automatic test_pc_in();
    load(2'b11, 64'h0, 64'h2000);
    n_checks++; if (pc !== 64'h2000) $display("FAIL in_pc: got %h want 2000", pc);
    else n_pass++;
    fetch(32'h55556666);
    n_checks++; if (IR !== 32'h55556666) $display("FAIL in_ir: got %h want 55556666", IR);
    else n_pass++;
  endtask

  task automatic test_hold();
    load(2'b00, 64'h0, 64'h0);
    n_checks++;
    if (pc !== 64'h2000 || imem_addr !== 64'h2000 || imem_req !== 1'b1 || ir_valid !== 1'b0)
      $display("FAIL hold_refetch: pc=%h addr=%h req=%b v=%b want 2000 2000 1 0",
               pc, imem_addr, imem_req, ir_valid);
    else n_pass++;
    fetch(32'h77778888);
    n_checks++; if (IR !== 32'h77778888) $display("FAIL hold_ir: got %h want 77778888", IR);
    else n_pass++;
  endtask

  task automatic test_wrap();
    // Top two bits of k fall off the shift: offset is +4.
    load(2'b10, 64'hC000_0000_0000_0001, 64'h0);
    n_checks++; if (pc !== 64'h2004) $display("FAIL jump_k_trunc: got %h want 2004", pc);
    else n_pass++;
    fetch(32'h0);
    load(2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    n_checks++; if (pc_plus4 !== 64'h0) $display("FAIL plus4_wrap: got %h want 0", pc_plus4);
    else n_pass++;
    fetch(32'h0);
    load(2'b01, 64'h0, 64'h0);
    n_checks++; if (pc !== 64'h0) $display("FAIL pc_wrap: got %h want 0", pc);
    else n_pass++;
    fetch(32'h0);
  endtask

  task automatic test_load_ignored();
    load(2'b01, 64'h0, 64'h0);
    pc_load = 1'b1;
    pc_sel  = 2'b11;
    pc_in   = 64'h5000;
    tick();
    pc_load = 1'b0;
    n_checks++;
    if (pc !== 64'h4 || imem_req !== 1'b1 || imem_addr !== 64'h4)
      $display("FAIL load_in_req: pc=%h req=%b addr=%h want 4 1 4", pc, imem_req, imem_addr);
    else n_pass++;
    fetch(32'h9999AAAA);
  endtask

  task automatic test_ack_ignored();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack   = 1'b0;
    n_checks++;
    if (IR !== 32'h9999AAAA || imem_req !== 1'b0 || ir_valid !== 1'b1)
      $display("FAIL ack_in_hold: ir=%h req=%b v=%b want 9999aaaa 0 1", IR, imem_req, ir_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    load(2'b01, 64'h0, 64'h0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (pc !== 64'h0 || IR !== 32'h0 || ir_valid !== 1'b0 || imem_req !== 1'b0 ||
        imem_addr !== 64'h0 || pc_plus4 !== 64'h4 || fault !== 1'b0)
      $display("FAIL reset_async: pc=%h ir=%h v=%b req=%b addr=%h p4=%h f=%b",
               pc, IR, ir_valid, imem_req, imem_addr, pc_plus4, fault);
    else n_pass++;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFEF00D;
    tick();
    n_checks++; if (IR !== 32'h0) $display("FAIL reset_late_ack: got %h want 0", IR);
    else n_pass++;
    reset = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (IR !== 32'h0 || ir_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL idle_ack: ir=%h v=%b req=%b want 0 0 1", IR, ir_valid, imem_req);
    else n_pass++;
  endtask

  task automatic test_misalign();
    fetch(32'h12345678);
    load(2'b11, 64'h0, 64'h2002);
`ifdef IFU_ALIGN_CHK_EN
    n_checks++;
    if (fault !== 1'b1 || pc !== 64'h2002 || imem_req !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL misalign_trap: f=%b pc=%h req=%b v=%b want 1 2002 0 0",
               fault, pc, imem_req, ir_valid);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || fault !== 1'b1)
      $display("FAIL misalign_park: req=%b f=%b want 0 1", imem_req, fault);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (fault !== 1'b0) $display("FAIL misalign_clear: got %b want 0", fault);
    else n_pass++;
    reset = 1'b1;
`else
    n_checks++;
    if (pc !== 64'h2000 || fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h2000)
      $display("FAIL misalign_force: pc=%h f=%b req=%b addr=%h want 2000 0 1 2000",
               pc, fault, imem_req, imem_addr);
    else n_pass++;
    fetch(32'hABCDEF01);
    n_checks++;
    if (IR !== 32'hABCDEF01 || ir_valid !== 1'b1)
      $display("FAIL misalign_fetch: ir=%h v=%b want abcdef01 1", IR, ir_valid);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_plus4();
    test_wait_states();
    test_jump();
    test_pc_in();
    test_hold();
    test_wrap();
    test_load_ignored();
    test_ack_ignored();
    test_reset_mid();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
